// File: rtl/reaction_pkg.sv
// Shared constants for the reaction-timer control stage: state codes,
// wait-time width and default timing parameters.
package reaction_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_GO    = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FALSE = 3'd4;

    localparam int WAIT_W           = 13;
    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_MAX_REACT_MS = 9999;

endpackage

// File: rtl/reaction_fsm_ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 while enabled and pulses Tick
// on the last count. Clr restarts the count so each state begins a fresh ms.
module ms_tick_gen
    import reaction_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    input  logic Clr,
    output logic Tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Clr || !En || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tick = En && (cnt_q == LAST);

endmodule

// File: rtl/reaction_fsm.sv
// Reaction-timer control FSM: random wait, GO LED, reaction measurement.
// Define REACTION_BEST_EN to add the BestTime (best non-timeout result) output.
module reaction_fsm
    import reaction_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int MAX_REACT_MS = DEF_MAX_REACT_MS,
    parameter int RT_W         = 14
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Stop,
    input  logic [WAIT_W-1:0] RandomValue,
    output logic              Led,
    output logic [RT_W-1:0]   ReactTime,
    output logic              Valid,
    output logic              FalseStart,
    output logic              Timeout,
`ifdef REACTION_BEST_EN
    output logic [RT_W-1:0]   BestTime,
`endif
    output logic [2:0]        State
);

    localparam logic [RT_W-1:0] MAX_C  = RT_W'(MAX_REACT_MS);
    localparam logic [RT_W-1:0] MAX_M1 = RT_W'(MAX_REACT_MS - 1);

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [RT_W-1:0]   react_q, react_d;
    logic [RT_W-1:0]   rt_q, rt_d;
    logic              to_q, to_d;
    logic              tick;
    logic              tick_en;
    logic              tick_clr;

    assign tick_en  = (state_q == ST_WAIT) || (state_q == ST_GO);
    assign tick_clr = (state_d != state_q);

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clk  (Clk),
        .Rst  (Rst),
        .En   (tick_en),
        .Clr  (tick_clr),
        .Tick (tick)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        react_d = react_q;
        rt_d    = rt_q;
        to_d    = to_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FALSE: begin
                if (Start) begin
                    state_d = ST_WAIT;
                    wait_d  = (RandomValue == '0) ? WAIT_W'(1) : RandomValue;
                    to_d    = 1'b0;
                end
            end
            ST_WAIT: begin
                if (Stop) begin
                    state_d = ST_FALSE;
                end else if (tick) begin
                    if (wait_q == WAIT_W'(1)) begin
                        state_d = ST_GO;
                        react_d = '0;
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                end
            end
            ST_GO: begin
                // Stop takes priority over a coincident ceiling tick
                if (Stop) begin
                    state_d = ST_DONE;
                    rt_d    = react_q;
                    to_d    = 1'b0;
                end else if (tick) begin
                    if (react_q == MAX_M1) begin
                        state_d = ST_DONE;
                        rt_d    = MAX_C;
                        to_d    = 1'b1;
                    end else begin
                        react_d = react_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            react_q <= '0;
            rt_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            react_q <= react_d;
            rt_q    <= rt_d;
            to_q    <= to_d;
        end
    end

`ifdef REACTION_BEST_EN
    logic [RT_W-1:0] best_q, best_d;

    always_comb begin
        best_d = best_q;
        if ((state_q == ST_GO) && Stop && (react_q < best_q)) begin
            best_d = react_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            best_q <= '1;
        end else begin
            best_q <= best_d;
        end
    end

    assign BestTime = best_q;
`endif

    assign Led        = (state_q == ST_GO);
    assign Valid      = (state_q == ST_DONE);
    assign FalseStart = (state_q == ST_FALSE);
    assign Timeout    = to_q;
    assign ReactTime  = rt_q;
    assign State      = state_q;

endmodule

// File: tb/tb_reaction_fsm.sv
// Directed bench for reaction_fsm with TICK_DIV=4, MAX_REACT_MS=20.
// Build with +define+REACTION_BEST_EN to also check BestTime.
module tb_reaction_fsm;
    import reaction_pkg::*;

    localparam int RT_W = 14;

    logic            Clk = 1'b0;
    logic            Rst = 1'b1;
    logic            Start = 1'b0;
    logic            Stop = 1'b0;
    logic [12:0]     RandomValue = '0;
    logic            Led;
    logic [RT_W-1:0] ReactTime;
    logic            Valid;
    logic            FalseStart;
    logic            Timeout;
    logic [2:0]      State;
`ifdef REACTION_BEST_EN
    logic [RT_W-1:0] BestTime;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    reaction_fsm #(.TICK_DIV(4), .MAX_REACT_MS(20), .RT_W(RT_W)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Start       (Start),
        .Stop        (Stop),
        .RandomValue (RandomValue),
        .Led         (Led),
        .ReactTime   (ReactTime),
        .Valid       (Valid),
        .FalseStart  (FalseStart),
        .Timeout     (Timeout),
`ifdef REACTION_BEST_EN
        .BestTime    (BestTime),
`endif
        .State       (State)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        start;
        logic        stop;
        logic [12:0] rv;
        int          idle;
        logic [2:0]  st;
        logic        led;
        logic [13:0] rt;
        logic        valid;
        logic        fs;
        logic        to;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One clock edge with the given pulses; outputs are sampled 1 time unit later.
    task automatic edge1(input logic st, input logic sp, input logic r, input logic [12:0] v);
        Start = st;
        Stop = sp;
        Rst = r;
        RandomValue = v;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Stop = 1'b0;
        Rst = 1'b0;
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) edge1(1'b0, 1'b0, 1'b0, RandomValue);
    endtask

    task automatic chk_all(input string p, input logic [2:0] st, input logic led,
                           input logic [13:0] rt, input logic vl, input logic fs, input logic to);
        chk({p, ".state"}, 32'(State), 32'(st));
        chk({p, ".led"}, 32'(Led), 32'(led));
        chk({p, ".react"}, 32'(ReactTime), 32'(rt));
        chk({p, ".valid"}, 32'(Valid), 32'(vl));
        chk({p, ".false"}, 32'(FalseStart), 32'(fs));
        chk({p, ".timeout"}, 32'(Timeout), 32'(to));
    endtask

    // Full round with RandomValue=1; Stop after n ticks in GO, or let it time out.
    task automatic play_round(input int n, input logic tmo);
        edge1(1'b1, 1'b0, 1'b0, 13'd1);
        idle_n(4);
        chk($sformatf("round%0d.go", n), 32'(State), 32'(ST_GO));
        if (tmo) begin
            idle_n(80);
            chk_all("round_tmo", ST_DONE, 1'b0, 14'd20, 1'b1, 1'b0, 1'b1);
        end else begin
            idle_n(4 * n);
            edge1(1'b0, 1'b1, 1'b0, 13'd1);
            chk_all($sformatf("round%0d", n), ST_DONE, 1'b0, 14'(n), 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        //         start stop rv  idle state     led rt  vld fs to
        tv.push_back('{0, 0, 13'd0,  0,  ST_IDLE,  0, 14'd0,  0, 0, 0}); // reset state
        tv.push_back('{1, 0, 13'd3,  0,  ST_WAIT,  0, 14'd0,  0, 0, 0});
        tv.push_back('{0, 0, 13'd3,  10, ST_WAIT,  0, 14'd0,  0, 0, 0});
        tv.push_back('{0, 0, 13'd3,  0,  ST_GO,    1, 14'd0,  0, 0, 0}); // 12 edges after Start
        tv.push_back('{1, 0, 13'd3,  19, ST_GO,    1, 14'd0,  0, 0, 0}); // Start in GO ignored
        tv.push_back('{0, 1, 13'd3,  0,  ST_DONE,  0, 14'd5,  1, 0, 0}); // 5 ticks
        tv.push_back('{0, 1, 13'd3,  5,  ST_DONE,  0, 14'd5,  1, 0, 0}); // hold in DONE
        tv.push_back('{1, 0, 13'd10, 0,  ST_WAIT,  0, 14'd5,  0, 0, 0});
        tv.push_back('{0, 0, 13'd10, 6,  ST_WAIT,  0, 14'd5,  0, 0, 0});
        tv.push_back('{0, 1, 13'd10, 0,  ST_FALSE, 0, 14'd5,  0, 1, 0}); // Stop on tick 2
        tv.push_back('{1, 0, 13'd1,  0,  ST_WAIT,  0, 14'd5,  0, 0, 0});
        tv.push_back('{0, 0, 13'd1,  3,  ST_GO,    1, 14'd5,  0, 0, 0});
        tv.push_back('{0, 0, 13'd1,  78, ST_GO,    1, 14'd5,  0, 0, 0});
        tv.push_back('{0, 0, 13'd1,  0,  ST_DONE,  0, 14'd20, 1, 0, 1}); // ceiling
        tv.push_back('{1, 0, 13'd1,  0,  ST_WAIT,  0, 14'd20, 0, 0, 0});
        tv.push_back('{0, 0, 13'd1,  3,  ST_GO,    1, 14'd20, 0, 0, 0});
        tv.push_back('{0, 0, 13'd1,  78, ST_GO,    1, 14'd20, 0, 0, 0});
        tv.push_back('{0, 1, 13'd1,  0,  ST_DONE,  0, 14'd19, 1, 0, 0}); // Stop on final tick
        tv.push_back('{1, 0, 13'd0,  0,  ST_WAIT,  0, 14'd19, 0, 0, 0}); // 0 clamps to 1
        tv.push_back('{1, 0, 13'd5,  2,  ST_WAIT,  0, 14'd19, 0, 0, 0}); // Start in WAIT ignored
        tv.push_back('{0, 0, 13'd5,  0,  ST_GO,    1, 14'd19, 0, 0, 0});

        edge1(1'b0, 1'b0, 1'b1, 13'd0);
        edge1(1'b0, 1'b0, 1'b1, 13'd0);

        for (int i = 0; i < tv.size(); i++) begin
            edge1(tv[i].start, tv[i].stop, 1'b0, tv[i].rv);
            idle_n(tv[i].idle);
            chk_all($sformatf("v%0d", i), tv[i].st, tv[i].led, tv[i].rt,
                    tv[i].valid, tv[i].fs, tv[i].to);
        end

        // Reset while react_cnt=7, then Start+Stop together in IDLE
        idle_n(28);
        chk("rstgo.pre", 32'(State), 32'(ST_GO));
        edge1(1'b0, 1'b0, 1'b1, 13'd1);
        chk_all("rstgo", ST_IDLE, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0);
        edge1(1'b1, 1'b1, 1'b0, 13'd1);
        chk_all("startstop", ST_WAIT, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0);
        idle_n(4);
        chk("after_rst.go", 32'(State), 32'(ST_GO));
        idle_n(8);
        edge1(1'b0, 1'b1, 1'b0, 13'd1);
        chk_all("after_rst", ST_DONE, 1'b0, 14'd2, 1'b1, 1'b0, 1'b0);

        // Best-time tracking across rounds
        edge1(1'b0, 1'b0, 1'b1, 13'd0);
`ifdef REACTION_BEST_EN
        chk("best.reset", 32'(BestTime), 32'(14'h3FFF));
`endif
        play_round(8, 1'b0);
`ifdef REACTION_BEST_EN
        chk("best.r8", 32'(BestTime), 32'd8);
`endif
        play_round(5, 1'b0);
`ifdef REACTION_BEST_EN
        chk("best.r5", 32'(BestTime), 32'd5);
`endif
        play_round(12, 1'b0);
`ifdef REACTION_BEST_EN
        chk("best.r12", 32'(BestTime), 32'd5);
`endif
        play_round(20, 1'b1);
`ifdef REACTION_BEST_EN
        chk("best.tmo", 32'(BestTime), 32'd5);
`endif
        edge1(1'b0, 1'b0, 1'b1, 13'd0);
        chk_all("final_rst", ST_IDLE, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0);
`ifdef REACTION_BEST_EN
        chk("best.rst", 32'(BestTime), 32'(14'h3FFF));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
